// File: rtl/tile_xfer_pkg.sv
// Shared state codes, gap-counter width and word-size helpers for the tile transfer scheduler.
package tile_xfer_pkg;

  localparam int GAP_W          = 8;
  localparam int DATA_W         = 32;
  localparam int BYTES_PER_WORD = DATA_W / 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CFG   = 3'd1;
  localparam state_t ST_GAP_L = 3'd2;
  localparam state_t ST_GAP_S = 3'd3;
  localparam state_t ST_XFER  = 3'd4;
  localparam state_t ST_NEXT  = 3'd5;
  localparam state_t ST_FIN   = 3'd6;

  function automatic int bytes_per_word(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/tile_xfer_scheduler_gap_timer.sv
// Loadable down-counter; expire is high in the last counted cycle so the caller's
// registered pulse lands exactly load_val cycles after the load.
module gap_timer
  import tile_xfer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [GAP_W-1:0] load_val,
  output logic             expire
);

  logic [GAP_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == GAP_W'(1));

endmodule

// File: rtl/tile_xfer_scheduler.sv
// Splits one transfer into tiles and sequences config, load start and store start per tile,
// waiting for both completion pulses before advancing addresses and the remaining count.
module tile_xfer_scheduler
  import tile_xfer_pkg::*;
#(
  parameter int AW        = 12,
  parameter int DW        = 32,
  parameter int LOAD_GAP  = 10,
  parameter int STORE_GAP = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] src_base,
  input  logic [DW-1:0] dst_base,
  input  logic [DW-1:0] total_len,
  input  logic [AW-1:0] tile_len,
  output logic [DW-1:0] param_raddr,
  output logic [DW-1:0] param_waddr,
  output logic [AW-1:0] param_iolen,
  output logic          config_done,
  output logic          load_data_start,
  input  logic          load_data_done,
  output logic          store_data_start,
  input  logic          store_data_done,
  output logic          busy,
  output logic [15:0]   tile_idx,
  output logic          task_done,
  output logic          err
);

  localparam logic [DW-1:0]    WORD_BYTES   = DW'(bytes_per_word(DW));
  localparam logic [GAP_W-1:0] LOAD_CYCLES  = GAP_W'(LOAD_GAP);
  localparam logic [GAP_W-1:0] STORE_CYCLES = GAP_W'(STORE_GAP);

  state_t           state;
  logic [DW-1:0]    raddr;
  logic [DW-1:0]    waddr;
  logic [DW-1:0]    remaining;
  logic [AW-1:0]    tile_len_q;
  logic [DW-1:0]    tile_words;
  logic [DW-1:0]    step;
  logic [DW-1:0]    remaining_nxt;
  logic             ld_seen;
  logic             st_seen;
  logic             both_done;
  logic             accept;
  logic             enter_cfg;
  logic             gap_load;
  logic [GAP_W-1:0] gap_val;
  logic             gap_expire;

  // Tile size is the smaller of the tile limit and what is left, compared at full width.
  function automatic logic [AW-1:0] clamp_len(input logic [DW-1:0] limit,
                                              input logic [DW-1:0] avail);
    return (limit < avail) ? limit[AW-1:0] : avail[AW-1:0];
  endfunction

  assign accept        = (state == ST_IDLE) && start && (tile_len != '0) && (total_len != '0);
  assign tile_words    = DW'(param_iolen);
  assign step          = tile_words * WORD_BYTES;
  assign remaining_nxt = remaining - tile_words;
  assign enter_cfg     = accept || ((state == ST_NEXT) && (remaining_nxt != '0));
  // Live pulses count too, so a done in the XFER cycle itself advances without a wait state.
  assign both_done     = (ld_seen || load_data_done) && (st_seen || store_data_done);
  assign gap_load      = (state == ST_CFG) || ((state == ST_GAP_L) && gap_expire);
  assign gap_val       = (state == ST_CFG) ? LOAD_CYCLES : STORE_CYCLES;
  assign busy          = (state != ST_IDLE);
  assign task_done     = (state == ST_FIN);

  gap_timer u_gap_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (gap_load),
    .load_val (gap_val),
    .expire   (gap_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= ST_IDLE;
      config_done      <= 1'b0;
      load_data_start  <= 1'b0;
      store_data_start <= 1'b0;
      err              <= 1'b0;
    end else begin
      config_done      <= 1'b0;
      load_data_start  <= 1'b0;
      store_data_start <= 1'b0;
      err              <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (tile_len == '0) begin
              err <= 1'b1;
            end else if (total_len == '0) begin
              state <= ST_FIN;
            end else begin
              state <= ST_CFG;
            end
          end
        end
        ST_CFG: begin
          config_done <= 1'b1;
          state       <= ST_GAP_L;
        end
        ST_GAP_L: begin
          if (gap_expire) begin
            load_data_start <= 1'b1;
            state           <= ST_GAP_S;
          end
        end
        ST_GAP_S: begin
          if (gap_expire) begin
            store_data_start <= 1'b1;
            state            <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (both_done) begin
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          state <= (remaining_nxt == '0) ? ST_FIN : ST_CFG;
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raddr       <= '0;
      waddr       <= '0;
      remaining   <= '0;
      tile_len_q  <= '0;
      tile_idx    <= '0;
      param_raddr <= '0;
      param_waddr <= '0;
      param_iolen <= '0;
    end else if (accept) begin
      raddr      <= src_base;
      waddr      <= dst_base;
      remaining  <= total_len;
      tile_len_q <= tile_len;
      tile_idx   <= '0;
    end else if (state == ST_CFG) begin
      param_iolen <= clamp_len(DW'(tile_len_q), remaining);
      param_raddr <= raddr;
      param_waddr <= waddr;
    end else if (state == ST_NEXT) begin
      raddr     <= raddr + step;
      waddr     <= waddr + step;
      remaining <= remaining_nxt;
      tile_idx  <= tile_idx + 16'd1;
    end
  end

  // Completion flags are sticky per tile and only cleared when the next tile is configured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_seen <= 1'b0;
      st_seen <= 1'b0;
    end else if (enter_cfg) begin
      ld_seen <= 1'b0;
      st_seen <= 1'b0;
    end else if (state != ST_IDLE) begin
      if (load_data_done) begin
        ld_seen <= 1'b1;
      end
      if (store_data_done) begin
        st_seen <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_tile_xfer_scheduler.sv
// Directed bench with a timestamp-level model of the tile schedule and a per-cycle compare.
module tb_tile_xfer_scheduler;

  localparam int AW   = 12;
  localparam int DW   = 32;
  localparam int LG   = 6;
  localparam int SG   = 4;
  localparam int NONE = -1;
  localparam int BIG  = 32'h7fffffff;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] src_base = '0, dst_base = '0, total_len = '0;
  logic [AW-1:0] tile_len = '0;
  logic [DW-1:0] param_raddr, param_waddr;
  logic [AW-1:0] param_iolen;
  logic          config_done, load_data_start, store_data_start;
  logic          load_data_done, store_data_done;
  logic          busy, task_done, err;
  logic [15:0]   tile_idx;

  tile_xfer_scheduler #(.AW(AW), .DW(DW), .LOAD_GAP(LG), .STORE_GAP(SG)) dut (
    .clk(clk), .rst(rst), .start(start), .src_base(src_base), .dst_base(dst_base),
    .total_len(total_len), .tile_len(tile_len), .param_raddr(param_raddr),
    .param_waddr(param_waddr), .param_iolen(param_iolen), .config_done(config_done),
    .load_data_start(load_data_start), .load_data_done(load_data_done),
    .store_data_start(store_data_start), .store_data_done(store_data_done),
    .busy(busy), .tile_idx(tile_idx), .task_done(task_done), .err(err)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Written by the main stimulus process only.
  int            req_seq = 0, req_c = 0, lit_seq = 0, lit_id = 0, to_seq = 0;
  logic [DW-1:0] req_src = '0, req_dst = '0, req_tot = '0;
  logic [AW-1:0] req_tl = '0;
  int            ld_delay = 20, st_delay = 20, stray_ld_at = NONE;

  // Written by the compare process only.
  int            n_vec = 0, n_err = 0;
  int            req_seen = 0, lit_seen = 0, to_seen = 0;
  int            cfg_at = NONE, ld_at = NONE, st_at = NONE, fin_at = NONE, err_at = NONE;
  int            busy_from = NONE, busy_to = NONE, ld_due = NONE, st_due = NONE;
  int            n_tiles = 0, m_tile = 0, d_cyc = 0;
  bit            e_cfg, e_ld, e_st, e_fin, e_err, e_busy;
  logic [DW-1:0] exp_raddr[64], exp_waddr[64], obs_raddr[64], obs_waddr[64];
  logic [AW-1:0] exp_iolen[64], obs_iolen[64];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit model_busy(input int c);
    return (busy_from != NONE) && (c >= busy_from) && (c <= busy_to);
  endfunction

  // Builds the expected tile list straight from the transfer arguments.
  task automatic model_start(input int c);
    logic [DW-1:0] rem, r, w, len;
    if (model_busy(c)) return;
    if (req_tl == '0) begin
      err_at = c + 1;
      return;
    end
    busy_from = c + 1;
    if (req_tot == '0) begin
      busy_to = c + 1;
      fin_at  = c + 1;
      return;
    end
    busy_to = BIG;
    rem = req_tot; r = req_src; w = req_dst; n_tiles = 0;
    while (rem != 0 && n_tiles < 64) begin
      len = (rem < DW'(req_tl)) ? rem : DW'(req_tl);
      exp_raddr[n_tiles] = r;
      exp_waddr[n_tiles] = w;
      exp_iolen[n_tiles] = len[AW-1:0];
      r = r + len * 4;
      w = w + len * 4;
      rem = rem - len;
      n_tiles++;
    end
    m_tile = 0;
    cfg_at = c + 2;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      cfg_at = NONE; ld_at = NONE; st_at = NONE; fin_at = NONE; err_at = NONE;
      busy_from = NONE; busy_to = NONE; ld_due = NONE; st_due = NONE;
      m_tile = 0; n_tiles = 0;
      req_seen = req_seq;
      chk("rst_busy", busy, 0);
      chk("rst_config_done", config_done, 0);
      chk("rst_load_start", load_data_start, 0);
      chk("rst_store_start", store_data_start, 0);
      chk("rst_task_done", task_done, 0);
      chk("rst_err", err, 0);
      chk("rst_tile_idx", tile_idx, 0);
      chk("rst_param_raddr", param_raddr, 0);
      chk("rst_param_waddr", param_waddr, 0);
      chk("rst_param_iolen", param_iolen, 0);
    end else begin
      if (req_seq != req_seen) begin
        req_seen = req_seq;
        model_start(req_c);
      end
      if (to_seq != to_seen) begin
        to_seen = to_seq;
        n_vec++;
        n_err++;
        $display("FAIL wait_bound: awaited pulse absent, cycle budget exhausted at cycle %0d", cyc);
      end
      if (lit_seq != lit_seen) begin
        lit_seen = lit_seq;
        case (lit_id)
          1: begin
            chk("even_model_raddr7", exp_raddr[7], 32'h0E00);
            chk("even_tile_idx_end", tile_idx, 8);
            chk("even_raddr7", obs_raddr[7], 32'h0E00);
            chk("even_waddr7", obs_waddr[7], 32'h1E00);
            chk("even_iolen7", obs_iolen[7], 128);
          end
          2: begin
            chk("part_iolen0", obs_iolen[0], 128);
            chk("part_iolen1", obs_iolen[1], 128);
            chk("part_iolen2", obs_iolen[2], 44);
            chk("part_raddr2", obs_raddr[2], 32'h2400);
            chk("part_tile_idx_end", tile_idx, 3);
          end
          3: begin
            chk("busy_start_tile_idx_end", tile_idx, 4);
            chk("busy_start_raddr3", obs_raddr[3], 32'h4600);
          end
          4: begin
            chk("fresh_tile_idx_end", tile_idx, 3);
            chk("fresh_iolen2", obs_iolen[2], 8);
            chk("fresh_raddr2", obs_raddr[2], 32'h90);
          end
          default: ;
        endcase
      end
      e_cfg  = (cyc == cfg_at);
      e_ld   = (cyc == ld_at);
      e_st   = (cyc == st_at);
      e_fin  = (cyc == fin_at);
      e_err  = (cyc == err_at);
      e_busy = model_busy(cyc);
      chk("config_done", config_done, e_cfg);
      chk("load_data_start", load_data_start, e_ld);
      chk("store_data_start", store_data_start, e_st);
      chk("task_done", task_done, e_fin);
      chk("err", err, e_err);
      chk("busy", busy, e_busy);
      if (e_cfg) begin
        chk("param_raddr", param_raddr, exp_raddr[m_tile]);
        chk("param_waddr", param_waddr, exp_waddr[m_tile]);
        chk("param_iolen", param_iolen, exp_iolen[m_tile]);
        chk("tile_idx", tile_idx, m_tile);
        obs_raddr[m_tile] = param_raddr;
        obs_waddr[m_tile] = param_waddr;
        obs_iolen[m_tile] = param_iolen;
        ld_at = cyc + LG;
      end
      if (e_ld) begin
        st_at  = cyc + SG;
        ld_due = cyc + ld_delay;
      end
      if (e_st) begin
        st_due = cyc + st_delay;
        d_cyc  = (ld_due > st_due) ? ld_due : st_due;
        m_tile++;
        if (m_tile < n_tiles) begin
          cfg_at = d_cyc + 3;
        end else begin
          fin_at  = d_cyc + 2;
          busy_to = d_cyc + 2;
        end
      end
    end
  end

  // Read/write side responder: done pulses at the model's scheduled cycles.
  initial begin
    load_data_done  = 1'b0;
    store_data_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      load_data_done  = (cyc == ld_due) || (cyc == stray_ld_at);
      store_data_done = (cyc == st_due);
    end
  end

  task automatic do_start(input logic [DW-1:0] s, input logic [DW-1:0] d,
                          input logic [DW-1:0] tot, input logic [AW-1:0] tl);
    @(posedge clk);
    #1;
    src_base = s; dst_base = d; total_len = tot; tile_len = tl;
    req_src = s; req_dst = d; req_tot = tot; req_tl = tl;
    req_c = cyc;
    start = 1'b1;
    req_seq++;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (task_done) break;
    end
    if (k == limit) to_seq++;
  endtask

  task automatic wait_store_tile(input int idx, input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (store_data_start && tile_idx == 16'(idx)) break;
    end
    if (k == limit) to_seq++;
  endtask

  task automatic wait_cfg_tile(input int idx, input int limit);
    int k;
    for (k = 0; k < limit; k++) begin
      @(negedge clk);
      if (config_done && tile_idx == 16'(idx)) break;
    end
    if (k == limit) to_seq++;
  endtask

  task automatic lit(input int id);
    @(posedge clk);
    #1;
    lit_id = id;
    lit_seq++;
    @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Even split, loads finish before stores.
    ld_delay = 20; st_delay = 20;
    do_start(32'h0, 32'h1000, 1024, 128);
    wait_done(2000);
    lit(1);

    // Partial last tile.
    do_start(32'h2000, 32'h3000, 300, 128);
    wait_done(1000);
    lit(2);

    // Store completes before load.
    ld_delay = 40; st_delay = 5;
    do_start(32'h100, 32'h200, 256, 100);
    wait_done(1000);

    // Both completions in the same cycle.
    ld_delay = SG + 7; st_delay = 7;
    do_start(32'h800, 32'h900, 200, 64);
    wait_done(1000);

    // Zero length, bad tile, and both at once.
    ld_delay = 20; st_delay = 20;
    do_start(32'h5, 32'h6, 0, 16);
    wait_done(10);
    do_start(32'h5, 32'h6, 100, 0);
    repeat (4) @(posedge clk);
    do_start(32'h5, 32'h6, 0, 0);
    repeat (4) @(posedge clk);

    // Start while busy is ignored.
    do_start(32'h4000, 32'h5000, 512, 128);
    wait_cfg_tile(1, 500);
    do_start(32'h9000, 32'hA000, 64, 8);
    wait_done(1000);
    lit(3);

    // Reset during XFER of the third tile, then a stray late load done.
    do_start(32'h6000, 32'h7000, 512, 128);
    wait_store_tile(2, 1000);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    stray_ld_at = cyc + 2;
    repeat (8) @(posedge clk);

    // Fresh transfer after reset.
    do_start(32'h10, 32'h20, 40, 16);
    wait_done(500);
    lit(4);
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
